id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage ARM pipeline. It sits directly downstream of the IF/ID pipeline register and consumes the fetched PC and instruction. It decodes the instruction, reads operands from the 15-entry register file (written back from WB), and evaluates the condition field against the status flags. It captures everything in an internal ID/EX pipeline register that supports bubble insertion and flush. Hazard-check operand indices are also exported combinationally.

## Interface
Parameters: none.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  branch taken; ID/EX register loads zeros
- hazard  in  1  from hazard unit; zeroes control outputs of this instruction
- PC_in  in  32  PC from IF/ID register (instruction address + 4)
- Instruction_in  in  32  instruction from IF/ID register
- SR  in  4  status flags {N,Z,C,V}
- WB_WB_EN  in  1  writeback enable
- WB_Dest  in  4  writeback register index
- WB_Value  in  32  writeback data
- src1, src2  out  4  combinational operand indices for hazard unit
- Two_src  out  1  combinational; instruction reads src2
- PC  out  32  registered PC
- WB_EN, MEM_R_EN, MEM_W_EN, B, S  out  1 each  registered control
- EXE_CMD  out  4  registered ALU command
- Val_Rn, Val_Rm  out  32  registered operand values
- imm  out  1  registered I bit
- Shift_operand  out  12  registered Instruction[11:0]
- Signed_imm_24  out  24  registered Instruction[23:0]
- Dest  out  4  registered Rd

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12].
- mode 00: data processing. EXE_CMD/opcode pairs: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
- WB_EN=1 for all of these except CMP/TST. S=Instruction[20]. Undefined opcode: EXE_CMD=0000, all control 0.
- mode 01: memory, EXE_CMD=0010, S=0. L=Instruction[20]: 1 → LDR (MEM_R_EN=1, WB_EN=1); 0 → STR (MEM_W_EN=1).
- mode 10: B=1, all other control 0. mode 11: all control 0.
- Condition codes over {N,Z,C,V}:
  - EQ Z, NE ~Z, CS C, CC ~C
  - MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z
  - GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 → 0
- Condition false or hazard=1: WB_EN, MEM_R_EN, MEM_W_EN, B and S forced 0. Data fields still load.
- Operand indices: src1=Rn. src2 = Rd for STR, else Instruction[3:0]. Two_src = ~I | MEM_W_EN(decoded).
- Register file: R0–R14, 32-bit.
  - Write on rising edge when WB_WB_EN=1 and WB_Dest≠15. Write to 15 is ignored.
  - Read is combinational with write-through: if WB_WB_EN and WB_Dest equals the read index (≠15), read returns WB_Value.
  - Read index 15 returns PC_in.
- Val_Rn reads src1. Val_Rm reads src2.

## Timing
- Instruction present at ID in cycle n appears on registered outputs after rising edge ending cycle n: latency 1.
- Priority at the edge: rst > flush > normal load. flush and hazard together → zeros.
- Reset (asynchronous assert, release synchronous to clk): every registered output 0. Register file Ri = i for i=0..14.
- Reset mid-operation discards any in-flight instruction and any same-cycle writeback.
- WB write and ID read of the same register in one cycle: ID captures WB_Value.
- src1/src2/Two_src are valid in the same cycle as Instruction_in, with no register.

## Structure
- Shared package arm_pkg: opcode constants, EXE_CMD constants, condition-code constants, mode encodings.
- Sub-module register_file: 15×32 storage, write port, two read ports with bypass, R15→PC input.
- Condition check and decode stay inline.

## Test plan
- Reset released; ADD R3,R1,R2 (0xE0813002) → after one edge: WB_EN=1, EXE_CMD=0010, Val_Rn=1, Val_Rm=2, Dest=3.
- WB_WB_EN=1, WB_Dest=1, WB_Value=0x55 in the same cycle as the ADD above → Val_Rn=0x55. The next read of R1 also returns 0x55.
- MOVEQ R0,#5 (0x03A00005):
  - SR=0000 → all control 0.
  - SR=0100 → WB_EN=1, EXE_CMD=0001, imm=1.
- STR R4,[R2] (0xE5824000) → MEM_W_EN=1, WB_EN=0, src2=4, Two_src=1, Val_Rm=4.
- hazard=1 with ADD → all control 0. flush=1 → every output 0 including PC.
- Assert rst mid-stream after writing R5=0xAA → outputs 0, and R5 reads 5.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared encodings for the ARM decode stage
// Contents: instruction mode encodings, data-processing opcodes, ALU
// command codes, condition codes and the ID/EX pipeline record.
package arm_pkg;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_CO  = 2'b11
  } mode_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int NUM_REGS = 15;

  typedef struct packed {
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
  } id_ex_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - R0..R14 storage with write-through reads
// Ports:
//   clk, rst          clock, asynchronous active-low reset (Ri <= i)
//   pc                value returned for reads of index 15
//   we/wr_idx/wr_data writeback port; index 15 is ignored
//   rd_idx_a/b        read indices, rd_data_a/b combinational read data
import arm_pkg::*;

module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        we,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_idx_a,
  input  logic [3:0]  rd_idx_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b
);

  logic [31:0] regs [NUM_REGS];
  logic        wr_ok;

  assign wr_ok = we && (wr_idx != 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'(i);
      end
    end else if (wr_ok) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Same-cycle writeback bypasses the array so decode sees the new value.
  function automatic logic [31:0] read_port(input logic [3:0] idx);
    if (idx == 4'd15) begin
      return pc;
    end else if (wr_ok && (wr_idx == idx)) begin
      return wr_data;
    end else begin
      return regs[idx];
    end
  endfunction

  assign rd_data_a = read_port(rd_idx_a);
  assign rd_data_b = read_port(rd_idx_b);

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM instruction decode stage with ID/EX register
// Ports:
//   clk, rst (async active-low), flush (zero ID/EX), hazard (kill control)
//   PC_in, Instruction_in   from IF/ID
//   SR                      status flags {N,Z,C,V}
//   WB_WB_EN/WB_Dest/WB_Value writeback into the register file
//   src1, src2, Two_src     combinational operand info for the hazard unit
//   PC .. Dest              registered ID/EX outputs
import arm_pkg::*;

module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instruction_in,
  input  logic [3:0]  SR,
  input  logic        WB_WB_EN,
  input  logic [3:0]  WB_Dest,
  input  logic [31:0] WB_Value,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        Two_src,
  output logic [31:0] PC,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        B,
  output logic        S,
  output logic [3:0]  EXE_CMD,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic        imm,
  output logic [11:0] Shift_operand,
  output logic [23:0] Signed_imm_24,
  output logic [3:0]  Dest
);

  logic [3:0] cond;
  mode_e      mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;

  assign cond   = Instruction_in[31:28];
  assign mode   = mode_e'(Instruction_in[27:26]);
  assign i_bit  = Instruction_in[25];
  assign opcode = Instruction_in[24:21];
  assign s_bit  = Instruction_in[20];
  assign rn     = Instruction_in[19:16];
  assign rd     = Instruction_in[15:12];

  logic       dec_wb_en;
  logic       dec_mem_r_en;
  logic       dec_mem_w_en;
  logic       dec_b;
  logic       dec_s;
  logic [3:0] dec_exe_cmd;

  always_comb begin
    dec_wb_en    = 1'b0;
    dec_mem_r_en = 1'b0;
    dec_mem_w_en = 1'b0;
    dec_b        = 1'b0;
    dec_s        = 1'b0;
    dec_exe_cmd  = EXE_NOP;
    case (mode)
      MODE_DP: begin
        dec_wb_en = 1'b1;
        dec_s     = s_bit;
        case (opcode)
          OP_MOV: dec_exe_cmd = EXE_MOV;
          OP_MVN: dec_exe_cmd = EXE_MVN;
          OP_ADD: dec_exe_cmd = EXE_ADD;
          OP_ADC: dec_exe_cmd = EXE_ADC;
          OP_SUB: dec_exe_cmd = EXE_SUB;
          OP_SBC: dec_exe_cmd = EXE_SBC;
          OP_AND: dec_exe_cmd = EXE_AND;
          OP_ORR: dec_exe_cmd = EXE_ORR;
          OP_EOR: dec_exe_cmd = EXE_EOR;
          OP_CMP: begin
            dec_exe_cmd = EXE_SUB;
            dec_wb_en   = 1'b0;
          end
          OP_TST: begin
            dec_exe_cmd = EXE_AND;
            dec_wb_en   = 1'b0;
          end
          default: begin
            dec_wb_en = 1'b0;
            dec_s     = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        dec_exe_cmd = EXE_ADD;
        if (s_bit) begin
          dec_mem_r_en = 1'b1;
          dec_wb_en    = 1'b1;
        end else begin
          dec_mem_w_en = 1'b1;
        end
      end
      MODE_BR: dec_b = 1'b1;
      MODE_CO: ;
      default: ;
    endcase
  end

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ok;

  assign {flag_n, flag_z, flag_c, flag_v} = SR;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = flag_z;
      COND_NE: cond_ok = ~flag_z;
      COND_CS: cond_ok = flag_c;
      COND_CC: cond_ok = ~flag_c;
      COND_MI: cond_ok = flag_n;
      COND_PL: cond_ok = ~flag_n;
      COND_VS: cond_ok = flag_v;
      COND_VC: cond_ok = ~flag_v;
      COND_HI: cond_ok = flag_c & ~flag_z;
      COND_LS: cond_ok = ~flag_c | flag_z;
      COND_GE: cond_ok = (flag_n == flag_v);
      COND_LT: cond_ok = (flag_n != flag_v);
      COND_GT: cond_ok = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ok = flag_z | (flag_n != flag_v);
      COND_AL: cond_ok = 1'b1;
      COND_NV: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end

  // A store reads Rd as its data operand, so it takes the second read port.
  assign src1    = rn;
  assign src2    = dec_mem_w_en ? rd : Instruction_in[3:0];
  assign Two_src = ~i_bit | dec_mem_w_en;

  logic [31:0] rf_rn;
  logic [31:0] rf_rm;

  register_file u_register_file (
    .clk       (clk),
    .rst       (rst),
    .pc        (PC_in),
    .we        (WB_WB_EN),
    .wr_idx    (WB_Dest),
    .wr_data   (WB_Value),
    .rd_idx_a  (src1),
    .rd_idx_b  (src2),
    .rd_data_a (rf_rn),
    .rd_data_b (rf_rm)
  );

  logic   kill_ctrl;
  id_ex_t id_ex_d;
  id_ex_t id_ex_q;

  assign kill_ctrl = ~cond_ok | hazard;

  // EXE_CMD is left as decoded on a kill; with all enables low it is inert.
  always_comb begin
    id_ex_d               = '0;
    id_ex_d.pc            = PC_in;
    id_ex_d.wb_en         = dec_wb_en    & ~kill_ctrl;
    id_ex_d.mem_r_en      = dec_mem_r_en & ~kill_ctrl;
    id_ex_d.mem_w_en      = dec_mem_w_en & ~kill_ctrl;
    id_ex_d.b             = dec_b        & ~kill_ctrl;
    id_ex_d.s             = dec_s        & ~kill_ctrl;
    id_ex_d.exe_cmd       = dec_exe_cmd;
    id_ex_d.val_rn        = rf_rn;
    id_ex_d.val_rm        = rf_rm;
    id_ex_d.imm           = i_bit;
    id_ex_d.shift_operand = Instruction_in[11:0];
    id_ex_d.signed_imm_24 = Instruction_in[23:0];
    id_ex_d.dest          = rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q <= '0;
    end else if (flush) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign PC            = id_ex_q.pc;
  assign WB_EN         = id_ex_q.wb_en;
  assign MEM_R_EN      = id_ex_q.mem_r_en;
  assign MEM_W_EN      = id_ex_q.mem_w_en;
  assign B             = id_ex_q.b;
  assign S             = id_ex_q.s;
  assign EXE_CMD       = id_ex_q.exe_cmd;
  assign Val_Rn        = id_ex_q.val_rn;
  assign Val_Rm        = id_ex_q.val_rm;
  assign imm           = id_ex_q.imm;
  assign Shift_operand = id_ex_q.shift_operand;
  assign Signed_imm_24 = id_ex_q.signed_imm_24;
  assign Dest          = id_ex_q.dest;

endmodule
